// File: rtl/trapezoid_pkg.sv
// Shared types and constants for the trapezoid rasteriser.
package trapezoid_pkg;

    localparam int unsigned CW = 8;       // coordinate width
    localparam int unsigned AW = CW + 2;  // signed working width for edge arithmetic

    typedef logic [CW-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vertex_t;

    typedef enum logic [2:0] {IDLE, CAP1, CAP2, CAP3, SETUP, EMIT} state_e;

    typedef logic signed [AW-1:0] acc_t;

    // Saturate a signed working value into the unsigned coordinate range.
    function automatic coord_t clamp_coord(input acc_t v);
        if (v[AW-1]) begin
            return '0;
        end else if (|v[AW-2:CW]) begin
            return '1;
        end
        return v[CW-1:0];
    endfunction

endpackage

// File: rtl/trap_edge_div.sv
// Sequential signed restoring divider: quo = floor(num/den) (mode=0) or ceil(num/den) (mode=1),
// with rem = num - quo*den. den must be non-zero. Result is held until the next start.
module trap_edge_div
    import trapezoid_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   start,
    input  logic   mode,
    input  acc_t   num,
    input  coord_t den,
    output logic   done,
    output acc_t   quo,
    output acc_t   rem
);
    localparam int unsigned CntW = $clog2(AW + 1);

    logic [AW-1:0]   a_q, p_q, a_sh, p_sh;
    logic [CntW-1:0] cnt_q;
    logic            neg_q, mode_q, done_q;
    coord_t          den_q;
    acc_t            tq, tr, den_s;

    // One restoring step on the magnitude: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        p_sh = {p_q[AW-2:0], a_q[AW-1]};
        a_sh = {a_q[AW-2:0], 1'b0};
        if (p_sh >= {2'b00, den_q}) begin
            p_sh    = p_sh - {2'b00, den_q};
            a_sh[0] = 1'b1;
        end
    end

    // Iteration registers; a start always restarts the division.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
            den_q  <= '0;
        end else if (start) begin
            a_q    <= num[AW-1] ? -num : num;
            p_q    <= '0;
            neg_q  <= num[AW-1];
            mode_q <= mode;
            den_q  <= den;
            cnt_q  <= CntW'(AW);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            a_q   <= a_sh;
            p_q   <= p_sh;
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                done_q <= 1'b1;
            end
        end
    end

    // Turn the truncated magnitude result into the requested rounding.
    always_comb begin
        den_s = {2'b00, den_q};
        tq    = neg_q ? -$signed(a_q) : $signed(a_q);
        tr    = neg_q ? -$signed(p_q) : $signed(p_q);
        quo   = tq;
        rem   = tr;
        if (p_q != '0) begin
            if (!mode_q && neg_q) begin
                quo = tq - acc_t'(1);
                rem = tr + den_s;
            end else if (mode_q && !neg_q) begin
                quo = tq + acc_t'(1);
                rem = tr - den_s;
            end
        end
    end

    assign done = done_q;

endmodule

// File: rtl/trapezoid.sv
// Trapezoid rasteriser: captures four vertices and emits every covered pixel, bottom line first,
// x ascending. Edges are stepped per line with an exact quotient/remainder accumulator whose
// per-line increments come from one division at the start of the trapezoid.
// Optional feature: define TRAP_PT_COUNT_EN to add the pt_cnt pixel counter output.
module trapezoid
    import trapezoid_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          nt,
    input  logic [CW-1:0] xi,
    input  logic [CW-1:0] yi,
    output logic          busy,
    output logic          po,
    output logic [CW-1:0] xo,
    output logic [CW-1:0] yo
`ifdef TRAP_PT_COUNT_EN
    ,
    output logic [2*CW:0] pt_cnt
`endif
);
    state_e  state_q, state_d;
    vertex_t ul_q, dl_q;
    coord_t  xur_q, xdr_q, y_q, x_q, xr_q, xo_q, yo_q, h, xl_c, xr_c;
    logic    first_q, busy_q, po_q, div_go, l_done, r_done, step_ok, last_line, capture;
    acc_t    lq_q, lr_q, rq_q, rr_q, lq_n, lr_n, rq_n, rr_n;
    acc_t    lqd, lrd, rqd, rrd, l_num, r_num, h_s;

    assign h         = ul_q.y - dl_q.y;
    assign last_line = (y_q == ul_q.y);
    assign step_ok   = first_q || (l_done && r_done);
    assign capture   = (state_q == IDLE) && nt && !busy_q;
    assign l_num     = {2'b00, ul_q.x} - {2'b00, dl_q.x};
    assign r_num     = {2'b00, xur_q} - {2'b00, xdr_q};

    // Per-line increments: floor((x_top - x_bottom) / h) plus remainder, for each edge.
    trap_edge_div u_div_l (
        .clk(clk), .reset_n(reset_n), .start(div_go), .mode(1'b0),
        .num(l_num), .den(h), .done(l_done), .quo(lqd), .rem(lrd)
    );
    trap_edge_div u_div_r (
        .clk(clk), .reset_n(reset_n), .start(div_go), .mode(1'b0),
        .num(r_num), .den(h), .done(r_done), .quo(rqd), .rem(rrd)
    );

    // Edge accumulators for the line being set up; left rounds up, right rounds down.
    always_comb begin
        h_s  = {2'b00, h};
        lq_n = lq_q + lqd;
        lr_n = lr_q + lrd;
        if (lr_n >= h_s) begin
            lq_n = lq_n + acc_t'(1);
            lr_n = lr_n - h_s;
        end
        rq_n = rq_q + rqd;
        rr_n = rr_q + rrd;
        if (rr_n >= h_s) begin
            rq_n = rq_n + acc_t'(1);
            rr_n = rr_n - h_s;
        end
        if (first_q) begin
            lq_n = {2'b00, dl_q.x};
            lr_n = '0;
            rq_n = {2'b00, xdr_q};
            rr_n = '0;
        end
        xl_c = clamp_coord(lq_n + ((lr_n != '0) ? acc_t'(1) : acc_t'(0)));
        xr_c = clamp_coord(rq_n);
        if (h == '0) begin
            xl_c = (dl_q.x < ul_q.x) ? dl_q.x : ul_q.x;
            xr_c = (xdr_q > xur_q) ? xdr_q : xur_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and divider launch on the first line.
    always_comb begin
        state_d = state_q;
        div_go  = 1'b0;
        case (state_q)
            IDLE:  if (capture) state_d = CAP1;
            CAP1:  state_d = CAP2;
            CAP2:  state_d = CAP3;
            CAP3:  state_d = SETUP;
            SETUP: begin
                div_go = first_q && (h != '0);
                if (step_ok) begin
                    if (xl_c > xr_c) begin
                        state_d = last_line ? IDLE : SETUP;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT:  if (x_q == xr_q) state_d = last_line ? IDLE : SETUP;
            default: state_d = IDLE;
        endcase
    end

    // Vertex capture, line stepping and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ul_q    <= '0;
            dl_q    <= '0;
            xur_q   <= '0;
            xdr_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            xr_q    <= '0;
            lq_q    <= '0;
            lr_q    <= '0;
            rq_q    <= '0;
            rr_q    <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            po_q    <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
        end else begin
            po_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy falls here, one edge after the final pixel was registered
                    busy_q <= 1'b0;
                    if (capture) ul_q <= {xi, yi};
                end
                CAP1: xur_q <= xi;
                CAP2: dl_q <= {xi, yi};
                CAP3: begin
                    xdr_q   <= xi;
                    y_q     <= dl_q.y;
                    first_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                SETUP: begin
                    if (step_ok) begin
                        lq_q    <= lq_n;
                        lr_q    <= lr_n;
                        rq_q    <= rq_n;
                        rr_q    <= rr_n;
                        first_q <= 1'b0;
                        x_q     <= xl_c;
                        xr_q    <= xr_c;
                        if ((xl_c > xr_c) && !last_line) y_q <= y_q + coord_t'(1);
                    end
                end
                EMIT: begin
                    po_q <= 1'b1;
                    xo_q <= x_q;
                    yo_q <= y_q;
                    // x may wrap past 2^CW-1 here, but the line has already ended
                    x_q  <= x_q + coord_t'(1);
                    if ((x_q == xr_q) && !last_line) y_q <= y_q + coord_t'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef TRAP_PT_COUNT_EN
    logic [2*CW:0] pt_cnt_q;

    // Pixels emitted for the current trapezoid; holds once rendering ends.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pt_cnt_q <= '0;
        end else if (capture) begin
            pt_cnt_q <= '0;
        end else if (po_q) begin
            pt_cnt_q <= pt_cnt_q + (2*CW+1)'(1);
        end
    end

    assign pt_cnt = pt_cnt_q;
`endif

    assign busy = busy_q;
    assign po   = po_q;
    assign xo   = xo_q;
    assign yo   = yo_q;

endmodule

// File: tb/tb_trapezoid.sv
// Self-checking bench for trapezoid: directed shapes plus random trapezoids checked against an
// arithmetic reference that rasterises each line directly from the edge equations.
module tb_trapezoid;
    import trapezoid_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          nt = 1'b0;
    logic [CW-1:0] xi = '0;
    logic [CW-1:0] yi = '0;
    logic          busy, po;
    logic [CW-1:0] xo, yo;
`ifdef TRAP_PT_COUNT_EN
    logic [2*CW:0] pt_cnt;
`endif

    int total = 0;
    int bad = 0;
    int exp_x[$], exp_y[$], got_x[$], got_y[$];

    always #5 clk = ~clk;

    trapezoid dut (
        .clk(clk), .reset_n(reset_n), .nt(nt), .xi(xi), .yi(yi),
        .busy(busy), .po(po), .xo(xo), .yo(yo)
`ifdef TRAP_PT_COUNT_EN
        , .pt_cnt(pt_cnt)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int n, input int d);
        int q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    function automatic int cdiv(input int n, input int d);
        int q = n / d;
        if ((n % d) != 0 && n > 0) q = q + 1;
        return q;
    endfunction

    function automatic int clampc(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference pixel list straight from the edge equations.
    function automatic void build_model(input int xul, input int yu, input int xur,
                                        input int xdl, input int yd, input int xdr);
        int h, xl, xr;
        exp_x.delete();
        exp_y.delete();
        h = yu - yd;
        for (int y = yd; y <= yu; y++) begin
            if (h == 0) begin
                xl = (xdl < xul) ? xdl : xul;
                xr = (xdr > xur) ? xdr : xur;
            end else begin
                xl = xdl + cdiv((xul - xdl) * (y - yd), h);
                xr = xdr + fdiv((xur - xdr) * (y - yd), h);
            end
            xl = clampc(xl);
            xr = clampc(xr);
            for (int x = xl; x <= xr; x++) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
        end
    endfunction

    // Called at a negedge with busy low; returns at the negedge where busy is seen low again.
    task automatic run_trap(input string tag, input int xul, input int yu, input int xur,
                            input int xdl, input int yd, input int xdr);
        int cyc, first_cyc, last_cyc, drop_cyc, errs;
        bit done;
        build_model(xul, yu, xur, xdl, yd, xdr);
        got_x.delete();
        got_y.delete();
        nt = 1'b1; xi = CW'(xul); yi = CW'(yu);
        @(negedge clk); nt = 1'($urandom_range(0, 1)); xi = CW'(xur); yi = CW'(yu);
        @(negedge clk); nt = 1'($urandom_range(0, 1)); xi = CW'(xdl); yi = CW'(yd);
        @(negedge clk); nt = 1'($urandom_range(0, 1)); xi = CW'(xdr); yi = CW'(yd);
        @(negedge clk);
        check({tag, "_busy_rise"}, int'(busy), 1);
        cyc = 0; first_cyc = -1; last_cyc = -1; drop_cyc = -1; done = 1'b0;
        while (!done && cyc < 3000) begin
            if (po) begin
                got_x.push_back(int'(xo));
                got_y.push_back(int'(yo));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (!busy) begin
                done = 1'b1;
                drop_cyc = cyc;
            end else begin
                // stray strobes and junk vertices while busy must be ignored
                nt = 1'($urandom_range(0, 1));
                xi = CW'($urandom);
                yi = CW'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        nt = 1'b0;
        check({tag, "_terminates"}, int'(done), 1);
        check({tag, "_npix"}, got_x.size(), exp_x.size());
        errs = 0;
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) errs++;
        end
        check({tag, "_pix_errs"}, errs, 0);
        if (exp_x.size() > 0 && got_x.size() > 0) begin
            check({tag, "_first_xy"}, got_x[0] * 256 + got_y[0], exp_x[0] * 256 + exp_y[0]);
            check({tag, "_last_xy"}, got_x[$] * 256 + got_y[$], exp_x[$] * 256 + exp_y[$]);
            check({tag, "_latency_ok"}, int'(first_cyc + 1 <= 2 * CW + 8), 1);
            if (exp_y[$] == yu) check({tag, "_busy_drop"}, drop_cyc, last_cyc + 1);
        end
`ifdef TRAP_PT_COUNT_EN
        check({tag, "_pt_cnt"}, int'(pt_cnt), exp_x.size());
`endif
    endtask

    initial begin
        int yd, h, base;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_po", int'(po), 0);
        check("rst_xo", int'(xo), 0);
        check("rst_yo", int'(yo), 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_trap("t1", 2, 5, 6, 0, 1, 8);
        check("t1_cnt33", got_x.size(), 33);
        run_trap("t2_rect", 10, 20, 12, 10, 18, 12);
        check("t2_cnt9", got_x.size(), 9);
        run_trap("t3_flat", 3, 7, 5, 3, 7, 5);
        check("t3_cnt3", got_x.size(), 3);
        run_trap("t4_invert", 5, 4, 4, 0, 0, 9);
        run_trap("t5_edge255", 250, 2, 255, 250, 0, 255);
        check("t5_cnt18", got_x.size(), 18);

        // Reset while pixels are streaming, then confirm a fresh capture works.
        nt = 1'b1; xi = 8'd2; yi = 8'd5;
        @(negedge clk); nt = 1'b0; xi = 8'd6;
        @(negedge clk); xi = 8'd0; yi = 8'd1;
        @(negedge clk); xi = 8'd8;
        repeat (6) @(negedge clk);
        check("mid_po_active", int'(po), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_po", int'(po), 0);
        check("mid_rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        run_trap("post_rst", 10, 20, 12, 10, 18, 12);

        for (int i = 0; i < 16; i++) begin
            yd = $urandom_range(0, 240);
            if (i % 4 == 0) begin
                h = $urandom_range(0, 3);
                run_trap($sformatf("rnd%0d", i), $urandom_range(0, 255), yd + h,
                         $urandom_range(0, 255), $urandom_range(0, 255), yd,
                         $urandom_range(0, 255));
            end else begin
                h = $urandom_range(0, 12);
                base = $urandom_range(0, 215);
                run_trap($sformatf("rnd%0d", i), base + $urandom_range(0, 40), yd + h,
                         base + $urandom_range(0, 40), base + $urandom_range(0, 40), yd,
                         base + $urandom_range(0, 40));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
